addsub_serial: RTL
==================

ADDSUB_SERIAL -- requirements
Module: addsub_serial

Interface
REQ-001 Parameter W, default 8, operand and result width in bits; W >= 2.
REQ-002 Parameter D, default 2, digit width processed per cycle; 1 <= D <= W; W % D == 0.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request a new operation; sampled only in IDLE or DONE.
REQ-006 A  input  W  minuend/augend; sampled on the accepting edge.
REQ-007 B  input  W  subtrahend/addend; sampled on the accepting edge.
REQ-008 M  input  1  mode, 0 = A+B, 1 = A-B (two's complement); sampled on the accepting edge.
REQ-009 busy  output  1  high while a digit computation is in progress.
REQ-010 done  output  1  one-cycle pulse marking that the result outputs are valid.
REQ-011 S  output  W  result.
REQ-012 C  output  1  carry out of bit W-1; for subtraction, 1 means no borrow.
REQ-013 V  output  1  signed overflow.
REQ-014 Z  output  1  result equals zero.
REQ-015 N  output  1  result bit W-1.

Function
REQ-016 The block SHALL be an FSM with states IDLE, RUN and DONE; the reset state is IDLE.
REQ-017 In IDLE or DONE, start=1 SHALL cause the block to:
- latch A into the operand A register;
- latch B XOR {W{M}} into the operand B register;
- set the carry register to M;
- clear the digit counter;
- enter RUN.
REQ-018 start in RUN SHALL be ignored; operands, mode and the operation in progress are unaffected.
REQ-019 Each RUN cycle SHALL perform one digit step:
- add digit k of the A register, digit k of the B register and the carry register (D-bit adder plus carry);
- write the D-bit sum into S[k*D+D-1 : k*D];
- update the carry register;
- increment k.
REQ-020 Digits SHALL be processed LSB first, k = 0 .. W/D-1; RUN lasts exactly W/D cycles.
REQ-021 On the last digit, the block SHALL capture the carry into bit W-1 and the carry out of bit W-1; V SHALL equal their XOR.
REQ-022 After the last digit, the block SHALL enter DONE for one cycle with done=1, and set C, V, Z and N from the final sum.
REQ-023 From DONE, the block SHALL enter RUN if start=1, else IDLE.
REQ-024 Latency: when start is accepted on edge t, done SHALL be high in the cycle following edge t+W/D.
REQ-025 busy SHALL equal 1 exactly in RUN; done SHALL equal 1 exactly in DONE.
REQ-026 In RUN, S SHALL show the partial result; C, V, Z and N SHALL hold the previous operation's values until DONE.
REQ-027 After DONE, S, C, V, Z and N SHALL hold their values until the next operation completes.
REQ-028 When D == W, the operation SHALL complete in a single RUN cycle, with identical flag semantics.
REQ-029 Arithmetic SHALL be modulo 2^W; a subtraction yielding 0 SHALL give Z=1 and C=1.
REQ-030 For W % D != 0, the block SHALL not elaborate (static check).

Reset
REQ-031 While rst_n=0, the block SHALL immediately, regardless of clock, force:
- state to IDLE;
- the digit counter, carry and operand registers to 0;
- busy=0, done=0, S=0, C=0, V=0, Z=0, N=0.
REQ-032 A reset during RUN SHALL abort the operation; no done pulse SHALL follow, and the first start accepted after rst_n rises begins a fresh operation.

Verification
REQ-033 W=8, D=2, A=0x7F, B=0x01, M=0: busy for 4 cycles, then done -> S=0x80, C=0, V=1, N=1, Z=0.
REQ-034 W=8, D=2, A=0x05, B=0x05, M=1 -> S=0x00, C=1, V=0, Z=1, N=0; done exactly 5 cycles after the start edge.
REQ-035 W=8, D=2, A=0x80, B=0x01, M=1 -> S=0x7F, C=1, V=1, N=0; then start held high in DONE with A=0x01, B=0x02, M=1 -> back-to-back result S=0xFF, C=0, V=0, N=1.
REQ-036 Start pulsed twice more during RUN with different A/B -> ignored; the result matches the first operands; only one done pulse.
REQ-037 rst_n pulled low after 2 RUN cycles, asynchronously mid-cycle -> all outputs 0 immediately, no done pulse; the next start completes correctly.
REQ-038 Sweep with W=8, D=8 and W=8, D=1 over random A, B, M, checked against a reference model -> S, C, V, Z and N match; latency = W/D + 1 cycles.

Source files
------------

// File: rtl/addsub_serial_if.sv
// Operand/result bus for the digit-serial adder/subtractor.
interface addsub_serial_if #(
  parameter int unsigned W = 8
);
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         M;
  logic         busy;
  logic         done;
  logic [W-1:0] S;
  logic         C;
  logic         V;
  logic         Z;
  logic         N;

  modport master (
    output start, A, B, M,
    input  busy, done, S, C, V, Z, N
  );

  modport slave (
    input  start, A, B, M,
    output busy, done, S, C, V, Z, N
  );
endinterface

// File: rtl/addsub_serial.sv
// Digit-serial adder/subtractor: W/D cycles of D-bit adds, LSB digit first.
module addsub_serial #(
  parameter int unsigned W = 8,
  parameter int unsigned D = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  addsub_serial_if.slave bus
);

  localparam int unsigned ND     = W / D;
  localparam int unsigned KW     = (ND > 1) ? $clog2(ND) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(ND - 1);

  // Reject parameterisations the digit slicing cannot represent.
  if ((W < 2) || (D < 1) || (D > W) || ((W % D) != 0)) begin : g_bad_param
    $error("addsub_serial: invalid W/D combination");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic         cy_q, cy_d;
  logic [W-1:0] s_q, s_d;
  logic         c_q, c_d;
  logic         v_q, v_d;
  logic         z_q, z_d;
  logic         n_q, n_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  int unsigned  base;
  logic [D-1:0] a_dig;
  logic [D-1:0] b_dig;
  logic [D-1:0] sum_dig;
  logic         chain_c;
  logic         c_msb;

  // Ripple one D-bit digit of the operands with the running carry.
  always_comb begin
    base    = 32'(k_q) * D;
    a_dig   = D'(a_q >> base);
    b_dig   = D'(b_q >> base);
    sum_dig = '0;
    chain_c = cy_q;
    c_msb   = cy_q;
    for (int unsigned i = 0; i < D; i++) begin
      sum_dig[i] = a_dig[i] ^ b_dig[i] ^ chain_c;
      if (i == D - 1) c_msb = chain_c;
      chain_c = (a_dig[i] & b_dig[i]) | (chain_c & (a_dig[i] ^ b_dig[i]));
    end
  end

  // Next-state and datapath control; flags only change on the last digit.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    cy_d    = cy_q;
    s_d     = s_q;
    c_d     = c_q;
    v_d     = v_q;
    z_d     = z_q;
    n_d     = n_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.B ^ {W{bus.M}};
          cy_d    = bus.M;
          k_d     = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        s_d[base +: D] = sum_dig;
        cy_d           = chain_c;
        k_d            = k_q + KW'(1);
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = DONE;
          c_d     = chain_c;
          v_d     = c_msb ^ chain_c;
          z_d     = (s_d == '0);
          n_d     = s_d[W-1];
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cy_q    <= 1'b0;
      s_q     <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cy_q    <= cy_d;
      s_q     <= s_d;
      c_q     <= c_d;
      v_q     <= v_d;
      z_q     <= z_d;
      n_q     <= n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.S    = s_q;
  assign bus.C    = c_q;
  assign bus.V    = v_q;
  assign bus.Z    = z_q;
  assign bus.N    = n_q;

endmodule
